vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_if.sv | 17 +
 rtl/vga_timing.sv | 56 +++++
 tb/tb_vga_timing.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
// XGA 1024x768@60 timing constants shared by the sync generator and its consumers.
package vga_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  localparam cnt_t HOR_PIXELS      = 11'd1024;
  localparam cnt_t HOR_TOTAL       = 11'd1344;
  localparam cnt_t HOR_LAST        = 11'd1343;
  localparam cnt_t HOR_SYNC_START  = 11'd1048;
  localparam cnt_t HOR_SYNC_STOP   = 11'd1183;
  localparam cnt_t HOR_BLANK_START = 11'd1024;

  localparam cnt_t VER_PIXELS      = 11'd768;
  localparam cnt_t VER_TOTAL       = 11'd806;
  localparam cnt_t VER_LAST        = 11'd805;
  localparam cnt_t VER_SYNC_START  = 11'd771;
  localparam cnt_t VER_SYNC_STOP   = 11'd776;
  localparam cnt_t VER_BLANK_START = 11'd768;

endpackage

// File: rtl/vga_if.sv
`timescale 1ns/1ps
// Timing/pixel bundle passed between the sync generator and downstream drawing stages.
interface vga_if;
  import vga_pkg::*;

  cnt_t hcount;
  cnt_t vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  rgb_t rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_timing.sv
`timescale 1ns/1ps
// Free-running XGA sync generator: pixel/line counters with registered sync and blank decode.
module vga_timing
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  vga_if.out   vga_out
);

  cnt_t hcount_q, vcount_q;
  cnt_t hcount_d, vcount_d;
  logic hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic hsync_d, vsync_d, hblnk_d, vblnk_d;

  // Decode from the next counter values so the registered flags line up with the counts.
  always_comb begin
    hcount_d = hcount_q + cnt_t'(1);
    vcount_d = vcount_q;
    if (hcount_q == HOR_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VER_LAST) ? '0 : vcount_q + cnt_t'(1);
    end
    hsync_d = (hcount_d >= HOR_SYNC_START) && (hcount_d <= HOR_SYNC_STOP);
    hblnk_d = (hcount_d >= HOR_BLANK_START);
    vsync_d = (vcount_d >= VER_SYNC_START) && (vcount_d <= VER_SYNC_STOP);
    vblnk_d = (vcount_d >= VER_BLANK_START);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = '0;

endmodule

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_timing: a flat pixel-time model predicts every cycle's outputs.
module tb_vga_timing;

  typedef struct {
    int unsigned h;
    int unsigned v;
    bit          hs;
    bit          vs;
    bit          hb;
    bit          vb;
    bit          dec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  vga_if vga_bus ();

  vga_timing dut (
    .clk     (clk),
    .rst     (rst),
    .vga_out (vga_bus)
  );

  always #8 clk = ~clk;

  exp_t        sb[$];
  int unsigned t;
  int unsigned errors;
  int unsigned checks;
  logic [10:0] jump_h, jump_v;

  // Expected outputs at flat time t (cycles since frame start), wrapping every frame.
  function automatic exp_t model(int unsigned tt, bit dec);
    exp_t        e;
    int unsigned p;
    p     = tt % (1344 * 806);
    e.h   = p % 1344;
    e.v   = p / 1344;
    e.hs  = (e.h >= 1048) && (e.h <= 1183);
    e.hb  = (e.h >= 1024);
    e.vs  = (e.v >= 771) && (e.v <= 776);
    e.vb  = (e.v >= 768);
    e.dec = dec;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{h: 0, v: 0, hs: 0, vs: 0, hb: 0, vb: 0, dec: 1};
    return e;
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, act, req, t, $time);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("hcount", vga_bus.hcount, e.h);
      chk("vcount", vga_bus.vcount, e.v);
      chk("rgb", vga_bus.rgb, 0);
      if (e.dec) begin
        chk("hsync", vga_bus.hsync, e.hs);
        chk("hblnk", vga_bus.hblnk, e.hb);
        chk("vsync", vga_bus.vsync, e.vs);
        chk("vblnk", vga_bus.vblnk, e.vb);
      end
    end
  end

  task automatic run(int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
      sb.push_back(model(t, 1'b1));
    end
  endtask

  // Fast-forward the counters; the flags still reflect the old position for this one cycle.
  task automatic jump_to(int unsigned h, int unsigned v);
    @(posedge clk);
    #1;
    jump_h = h[10:0];
    jump_v = v[10:0];
    force dut.hcount_q = jump_h;
    force dut.vcount_q = jump_v;
    release dut.hcount_q;
    release dut.vcount_q;
    t = v * 1344 + h;
    sb.push_back(model(t, 1'b0));
  endtask

  task automatic apply_reset(int unsigned hold);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_hcount", vga_bus.hcount, 0);
    chk("async_vcount", vga_bus.vcount, 0);
    chk("async_hsync",  vga_bus.hsync,  0);
    chk("async_vsync",  vga_bus.vsync,  0);
    chk("async_hblnk",  vga_bus.hblnk,  0);
    chk("async_vblnk",  vga_bus.vblnk,  0);
    chk("async_rgb",    vga_bus.rgb,    0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      sb.push_back(zero_exp());
    end
    #2;
    rst = 1'b1;
    t   = 0;
  endtask

  initial begin
    rst    = 1'b1;
    errors = 0;
    checks = 0;
    t      = 0;
    repeat (3) @(posedge clk);

    apply_reset(2);
    run(40);
    run(1400);

    jump_to(490, 400);
    run(10);
    apply_reset(1);
    run(20);

    jump_to(1300, 766);
    run(11 * 1344);

    jump_to(1000, 804);
    run(2000);

    for (int i = 0; i < 8; i++) begin
      jump_to($urandom_range(0, 1343), $urandom_range(0, 805));
      run($urandom_range(50, 1500));
    end

    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
